// File: rtl/bf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf_pkg                                                        |
// | Description : Shared types and constants for the brainfuck loop controller. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package bf_pkg;

  localparam int c_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SKIP = 2'd1,
    ST_JUMP = 2'd2,
    ST_ERR  = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVF       = 2'd1,
    ERR_UNF       = 2'd2,
    ERR_UNMATCHED = 2'd3
  } err_code_e;

  // '[' and ']' together, or alongside end, decode as a plain instruction
  function automatic logic is_bracket_open(input logic op, input logic cl, input logic en);
    return op & ~cl & ~en;
  endfunction

  function automatic logic is_bracket_close(input logic op, input logic cl, input logic en);
    return cl & ~op & ~en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bf_loop_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf_loop_ctrl_if                                               |
// | Description : Decoder-to-loop-controller instruction handshake bundle.      |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
interface bf_loop_ctrl_if
  import bf_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W
);

  logic              instr_valid;
  logic              instr_ready;
  logic              instr_is_open;
  logic              instr_is_close;
  logic              instr_is_end;
  logic [ADDR_W-1:0] pc;
  logic              cell_zero;

  modport master (
    output instr_valid,
    output instr_is_open,
    output instr_is_close,
    output instr_is_end,
    output pc,
    output cell_zero,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_is_open,
    input  instr_is_close,
    input  instr_is_end,
    input  pc,
    input  cell_zero,
    output instr_ready
  );

endinterface
`default_nettype wire

// File: rtl/bf_loop_stack_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf_loop_stack_sync                                            |
// | Description : Clocked LIFO of loop start addresses; out-of-range ops ignored|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bf_loop_stack_sync
  import bf_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int DATA_W = c_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [IDX_W:0]    r_count;
  logic              w_do_push;
  logic              w_do_pop;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_top_idx;

  assign full      = (r_count == (IDX_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push & ~pop & ~full;
  assign w_do_pop  = pop & ~push & ~empty;
  assign w_wr_idx  = r_count[IDX_W-1:0];
  assign w_top_idx = r_count[IDX_W-1:0] - IDX_W'(1);
  assign top       = r_mem[w_top_idx];

  // Contents need no reset: only entries below r_count are ever read as valid
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + (IDX_W+1)'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - (IDX_W+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bf_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf_loop_ctrl                                                  |
// | Description : '[' / ']' sequencing: loop stack, skip scan, PC redirect.     |
// |               Define BF_LOOP_PROFILE_EN for loop_iters / max_depth outputs. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module bf_loop_ctrl
  import bf_pkg::*;
#(
  parameter int ADDR_W = c_ADDR_W,
  parameter int DEPTH  = 32,
  parameter int NEST_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bf_loop_ctrl_if.slave          bus,
  output logic                   skip_active,
  output logic                   pc_load,
  output logic [ADDR_W-1:0]      pc_target,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   err,
  output logic [1:0]             err_code
`ifdef BF_LOOP_PROFILE_EN
  ,
  output logic [31:0]            loop_iters,
  output logic [$clog2(DEPTH):0] max_depth
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  err_code_e         r_err_code;
  err_code_e         w_err_code_nxt;
  logic [NEST_W-1:0] r_nest;
  logic [NEST_W-1:0] w_nest_nxt;

  logic              w_accept;
  logic              w_open;
  logic              w_close;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;

  assign bus.instr_ready = (r_state == ST_RUN) || (r_state == ST_SKIP);
  assign w_accept        = bus.instr_valid & bus.instr_ready;
  assign w_open          = is_bracket_open(bus.instr_is_open, bus.instr_is_close, bus.instr_is_end);
  assign w_close         = is_bracket_close(bus.instr_is_open, bus.instr_is_close, bus.instr_is_end);

  bf_loop_stack_sync #(
    .DEPTH  (DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (bus.pc),
    .top       (w_top),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_err_code <= ERR_NONE;
      r_nest     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_err_code_nxt;
      r_nest     <= w_nest_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    w_nest_nxt     = r_nest;
    w_push         = 1'b0;
    w_pop          = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (w_open && !bus.cell_zero) begin
            if (w_full) begin
              w_state_nxt    = ST_ERR;
              w_err_code_nxt = ERR_OVF;
            end else begin
              w_push = 1'b1;
            end
          end else if (w_open) begin
            w_nest_nxt  = NEST_W'(1);
            w_state_nxt = ST_SKIP;
          end else if (w_close) begin
            if (w_empty) begin
              w_state_nxt    = ST_ERR;
              w_err_code_nxt = ERR_UNF;
            end else if (bus.cell_zero) begin
              w_pop = 1'b1;
            end else begin
              // Loop-back keeps the entry; the matching exit ']' pops it
              w_state_nxt = ST_JUMP;
            end
          end
        end
      end

      ST_SKIP: begin
        if (w_accept) begin
          if (bus.instr_is_end) begin
            w_state_nxt    = ST_ERR;
            w_err_code_nxt = ERR_UNMATCHED;
          end else if (w_open) begin
            if (&r_nest) begin
              w_state_nxt    = ST_ERR;
              w_err_code_nxt = ERR_UNMATCHED;
            end else begin
              w_nest_nxt = r_nest + NEST_W'(1);
            end
          end else if (w_close) begin
            w_nest_nxt = r_nest - NEST_W'(1);
            if (r_nest == NEST_W'(1)) begin
              w_state_nxt = ST_RUN;
            end
          end
        end
      end

      ST_JUMP: begin
        w_state_nxt = ST_RUN;
      end

      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end

      default: begin
        w_state_nxt = ST_ERR;
      end
    endcase
  end

  assign skip_active = (r_state == ST_SKIP);
  assign pc_load     = (r_state == ST_JUMP);
  assign pc_target   = pc_load ? (w_top + ADDR_W'(1)) : '0;
  assign err         = (r_state == ST_ERR);
  assign err_code    = r_err_code;
  assign depth       = w_count;

`ifdef BF_LOOP_PROFILE_EN
  logic [31:0]      r_loop_iters;
  logic [CNT_W-1:0] r_max_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop_iters <= '0;
      r_max_depth  <= '0;
    end else begin
      if (w_state_nxt == ST_JUMP && r_state != ST_JUMP && r_loop_iters != '1) begin
        r_loop_iters <= r_loop_iters + 32'd1;
      end
      if (w_count > r_max_depth) begin
        r_max_depth <= w_count;
      end
    end
  end

  assign loop_iters = r_loop_iters;
  assign max_depth  = r_max_depth;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bf_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bf_loop_ctrl                                               |
// | Description : Directed scoreboard bench for the loop controller.            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bf_loop_ctrl;
  import bf_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 32;
  localparam int NEST_W = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              skip_active;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [5:0]        depth;
  logic              err;
  logic [1:0]        err_code;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W-1:0] jump_q [$];
  logic [1:0]        err_q  [$];
  logic              prev_err = 1'b0;

  bf_loop_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  bf_loop_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NEST_W (NEST_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .skip_active (skip_active),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .depth       (depth),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every pc_load pulse and every err rising edge consumes one expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_load) begin
        if (jump_q.size() == 0) check("pc_load_unexpected", {31'd0, pc_load}, 32'd0);
        else                    check("pc_target", {22'd0, pc_target}, {22'd0, jump_q.pop_front()});
      end
      if (err && !prev_err) begin
        if (err_q.size() == 0) check("err_unexpected", {31'd0, err}, 32'd0);
        else                   check("err_code", {30'd0, err_code}, {30'd0, err_q.pop_front()});
      end
    end
    prev_err <= rst_n ? err : 1'b0;
  end

  task automatic idle_bus();
    bus.instr_valid    = 1'b0;
    bus.instr_is_open  = 1'b0;
    bus.instr_is_close = 1'b0;
    bus.instr_is_end   = 1'b0;
    bus.cell_zero      = 1'b0;
  endtask

  task automatic issue(input logic op, input logic cl, input logic en,
                       input logic [ADDR_W-1:0] pcv, input logic cz);
    logic acc;
    acc = 1'b0;
    bus.instr_valid    = 1'b1;
    bus.instr_is_open  = op;
    bus.instr_is_close = cl;
    bus.instr_is_end   = en;
    bus.pc             = pcv;
    bus.cell_zero      = cz;
    for (int k = 0; k < 8 && !acc; k++) begin
      acc = bus.instr_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", {31'd0, bus.instr_ready}, 32'd1);
    idle_bus();
  endtask

  task automatic settle_and_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    bus.pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("rst_depth", {26'd0, depth}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_skip", {31'd0, skip_active}, 32'd0);
    check("rst_pc_load", {31'd0, pc_load}, 32'd0);

    // Loop back: '[' @5 then ']' @9 with non-zero cell
    issue(1'b1, 1'b0, 1'b0, 10'd5, 1'b0);
    check("push_depth", {26'd0, depth}, 32'd1);
    jump_q.push_back(10'd6);
    issue(1'b0, 1'b1, 1'b0, 10'd9, 1'b0);
    check("jump_pc_load", {31'd0, pc_load}, 32'd1);
    check("jump_ready", {31'd0, bus.instr_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("post_jump_pc_load", {31'd0, pc_load}, 32'd0);
    check("post_jump_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("post_jump_depth", {26'd0, depth}, 32'd1);

    // Loop exit: ']' with zero cell pops
    issue(1'b0, 1'b1, 1'b0, 10'd9, 1'b1);
    check("exit_depth", {26'd0, depth}, 32'd0);
    check("exit_pc_load", {31'd0, pc_load}, 32'd0);

    // Both bracket flags and end-in-RUN are no-ops
    issue(1'b1, 1'b1, 1'b0, 10'd11, 1'b0);
    check("both_flags_depth", {26'd0, depth}, 32'd0);
    check("both_flags_err", {31'd0, err}, 32'd0);
    issue(1'b0, 1'b0, 1'b1, 10'd12, 1'b0);
    check("end_run_err", {31'd0, err}, 32'd0);
    check("end_run_skip", {31'd0, skip_active}, 32'd0);

    // Target wraps past the top of the address space
    issue(1'b1, 1'b0, 1'b0, 10'd1023, 1'b0);
    jump_q.push_back(10'd0);
    issue(1'b0, 1'b1, 1'b0, 10'd13, 1'b0);
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 1'b0, 10'd13, 1'b1);
    check("wrap_pop_depth", {26'd0, depth}, 32'd0);

    // Skip scan over '[', '+', ']', ']'
    issue(1'b1, 1'b0, 1'b0, 10'd20, 1'b1);
    check("skip_enter", {31'd0, skip_active}, 32'd1);
    issue(1'b1, 1'b0, 1'b0, 10'd21, 1'b0);
    check("skip_nested_open", {31'd0, skip_active}, 32'd1);
    issue(1'b0, 1'b0, 1'b0, 10'd22, 1'b0);
    check("skip_plain", {31'd0, skip_active}, 32'd1);
    issue(1'b0, 1'b1, 1'b0, 10'd23, 1'b0);
    check("skip_inner_close", {31'd0, skip_active}, 32'd1);
    issue(1'b0, 1'b1, 1'b0, 10'd24, 1'b0);
    check("skip_exit", {31'd0, skip_active}, 32'd0);
    check("skip_depth", {26'd0, depth}, 32'd0);

    // Reset asserted during the JUMP cycle
    issue(1'b1, 1'b0, 1'b0, 10'd30, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 10'd31, 1'b0);
    check("jump_before_reset", {31'd0, pc_load}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_pc_load", {31'd0, pc_load}, 32'd0);
    check("reset_depth", {26'd0, depth}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_ready", {31'd0, bus.instr_ready}, 32'd1);
    check("reset_err", {31'd0, err}, 32'd0);

    // Overflow on the 33rd push
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 1'b0, 10'(100 + i), 1'b0);
    check("full_depth", {26'd0, depth}, 32'd32);
    check("full_no_err", {31'd0, err}, 32'd0);
    err_q.push_back(2'd1);
    issue(1'b1, 1'b0, 1'b0, 10'd200, 1'b0);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("ovf_depth", {26'd0, depth}, 32'd32);
    settle_and_reset();

    // Underflow
    err_q.push_back(2'd2);
    issue(1'b0, 1'b1, 1'b0, 10'd40, 1'b0);
    check("unf_err", {31'd0, err}, 32'd1);
    settle_and_reset();

    // End reached while scanning
    issue(1'b1, 1'b0, 1'b0, 10'd50, 1'b1);
    err_q.push_back(2'd3);
    issue(1'b0, 1'b0, 1'b1, 10'd51, 1'b0);
    check("unmatched_end_err", {31'd0, err}, 32'd1);
    check("unmatched_end_skip", {31'd0, skip_active}, 32'd0);
    settle_and_reset();

    // Nest counter at all-ones then one more '['
    issue(1'b1, 1'b0, 1'b0, 10'd60, 1'b1);
    for (int i = 0; i < 254; i++) issue(1'b1, 1'b0, 1'b0, 10'd61, 1'b0);
    check("nest_max_skip", {31'd0, skip_active}, 32'd1);
    check("nest_max_no_err", {31'd0, err}, 32'd0);
    err_q.push_back(2'd3);
    issue(1'b1, 1'b0, 1'b0, 10'd62, 1'b0);
    check("nest_ovf_err", {31'd0, err}, 32'd1);
    settle_and_reset();

    check("jump_q_drained", jump_q.size(), 32'd0);
    check("err_q_drained", err_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bf_loop_ctrl.md
Name: bf_loop_ctrl

Overview:
- Sequences '[' and ']' handling for the brainfuck core.
- Owns a clocked loop-address stack. Decides push/pop/jump/skip per bracket instruction and drives the PC redirect.
- Sits between the instruction decoder/fetch unit and the data-cell ALU. Consumes the decoded bracket flags plus the current cell-zero status.

Parameters:
- ADDR_W, 10, program-address width
- DEPTH, 32, loop-stack entries (power of two)
- NEST_W, 8, width of skip-mode nesting counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  decoder presents an instruction at pc
- instr_ready  out  1  block accepts instruction this cycle
- instr_is_open  in  1  instruction is '['
- instr_is_close  in  1  instruction is ']'
- instr_is_end  in  1  end-of-program marker
- pc  in  ADDR_W  address of presented instruction
- cell_zero  in  1  current data cell == 0
- skip_active  out  1  core must fetch but not execute (scanning for matching ']')
- pc_load  out  1  one-cycle pulse: fetch must jump
- pc_target  out  ADDR_W  jump destination, valid with pc_load
- depth  out  $clog2(DEPTH)+1  current stack occupancy
- err  out  1  sticky error, core halts
- err_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 unmatched '['

Behaviour:
- Reset (async, rst_n low): state=RUN, stack empty, nest=0. All outputs 0 except instr_ready=1.
- States: RUN, SKIP, JUMP, ERR. Handshake: an instruction is consumed on clk edge when instr_valid & instr_ready.
- RUN, '[' with cell_zero=0: push pc. Accept in 1 cycle, stay RUN.
- RUN, '[' with cell_zero=1: no push. nest<=1, go SKIP. skip_active=1 from next cycle.
- RUN, ']' with cell_zero=0: stack unchanged. Go JUMP.
  - In JUMP: pc_load=1, pc_target=top+1 (wraps mod 2^ADDR_W), instr_ready=0 for exactly that cycle. Then RUN.
- RUN, ']' with cell_zero=1: pop, no jump, stay RUN.
- SKIP: every accepted instruction is discarded by the core.
  - '[' increments nest.
  - ']' decrements nest. If nest was 1, go RUN; skip_active drops the next cycle.
  - cell_zero ignored. Stack untouched.
- Overflow (push when depth==DEPTH): err_code=1, go ERR, stack unchanged.
- Underflow (']' in RUN with depth==0): err_code=2, go ERR.
- Unmatched '[': instr_is_end accepted in SKIP, or nest increment at all-ones, gives err_code=3, go ERR.
- instr_is_open and instr_is_close both set: instruction treated as non-bracket (no action).
- instr_is_end in RUN: no action.
- ERR: err=1, instr_ready=0, skip_active=0; held until reset.
- Non-bracket instructions in RUN: accepted in 1 cycle, no effect.
- Reset mid-JUMP or mid-SKIP: pc_load suppressed immediately, stack cleared.

Optional Feature:
- Macro: BF_LOOP_PROFILE_EN.
- Defined: adds output loop_iters [31:0]. It counts JUMP entries, saturates at 0xFFFF_FFFF, and clears on reset. Adds output max_depth, the high-water mark of depth.
- Undefined: no profiling ports or counters; behaviour otherwise identical.

Decomposition:
- Package bf_pkg holds:
  - ADDR_W default constant
  - ctrl state enum (RUN/SKIP/JUMP/ERR)
  - err_code enum (ERR_NONE, ERR_OVF, ERR_UNF, ERR_UNMATCHED)
- Sub-module bf_loop_stack_sync:
  - clocked push/pop with async reset
  - combinational top, full, empty, count
  - a push or pop that would overflow or underflow is ignored
- The controller FSM and nest counter stay in bf_loop_ctrl.

Test Plan:
- '[' at pc=5, cell_zero=0, then ']' at pc=9, cell_zero=0 -> depth=1; next cycle pc_load=1, pc_target=6, instr_ready=0 for one cycle.
- Same ']' with cell_zero=1 -> no pc_load, depth returns to 0.
- '[' cell_zero=1, then stream '[', '+', ']', ']' -> skip_active high across all four; drops the cycle after the final ']'; depth stays 0.
- 33 consecutive '[' with cell_zero=0 -> depth=32, then err=1, err_code=1, instr_ready=0.
- ']' on empty stack -> err_code=2. '[' cell_zero=1 followed by instr_is_end -> err_code=3.
- Assert rst_n low during a JUMP cycle -> pc_load=0 immediately, depth=0, err=0, instr_ready=1 after release.
